// File: rtl/mem_seq.sv
// mem_seq: control sequencer for a two-operand CPU core with a shared memory bus.
// Walks each instruction through fetch, decode, source/destination extension
// words and operand reads, execute, memory write-back and autoincrement.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   mem_rdy        memory completes the current bus cycle this clock
//   fmt_j, as, ad, cg, imm, wr   decoded instruction fields, stable per IR
//   MAB_sel        address source (0 = PC, 1 = Sout, 2 = CALC)
//   mem_req, MW    bus cycle active, memory write
//   RW, MPC, MD    register write, PC mux, Din mux
//   ir_ld, xs_ld, xd_ld, src_ld, dst_ld, exec   load and execute strobes
//   instr_cnt      retired-instruction count
//   state          current sequencer state
module mem_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rdy,
  input  logic             fmt_j,
  input  logic [1:0]       as,
  input  logic             ad,
  input  logic             cg,
  input  logic             imm,
  input  logic             wr,
  output logic [2:0]       MAB_sel,
  output logic             mem_req,
  output logic             MW,
  output logic             RW,
  output logic [1:0]       MPC,
  output logic [1:0]       MD,
  output logic             ir_ld,
  output logic             xs_ld,
  output logic             xd_ld,
  output logic             src_ld,
  output logic             dst_ld,
  output logic             exec,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] EXT_SRC = 4'd2;
  localparam logic [3:0] SRC_RD  = 4'd3;
  localparam logic [3:0] EXT_DST = 4'd4;
  localparam logic [3:0] DST_RD  = 4'd5;
  localparam logic [3:0] EXEC    = 4'd6;
  localparam logic [3:0] WB_MEM  = 4'd7;
  localparam logic [3:0] INC     = 4'd8;
  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic             r_ainc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_idx_src;
  logic             w_retire;
  logic [2:0]       w_mab;
  logic             w_req, w_mw, w_rw, w_ir, w_xs, w_xd, w_src, w_dst, w_ex;
  logic [1:0]       w_mpc, w_md;
  // indexed/symbolic source needs an extension word and then a memory read
  assign w_idx_src = (as == 2'b01) && !cg;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = mem_rdy ? DECODE : FETCH;
      DECODE:  w_next = fmt_j ? EXEC :
                        (w_idx_src || imm) ? EXT_SRC :
                        (as[1] && !cg) ? SRC_RD :
                        ad ? EXT_DST : EXEC;
      EXT_SRC: w_next = !mem_rdy ? EXT_SRC :
                        (as == 2'b01) ? SRC_RD :
                        ad ? EXT_DST : EXEC;
      SRC_RD:  w_next = !mem_rdy ? SRC_RD : ad ? EXT_DST : EXEC;
      EXT_DST: w_next = mem_rdy ? DST_RD : EXT_DST;
      DST_RD:  w_next = mem_rdy ? EXEC : DST_RD;
      EXEC:    w_next = (ad && wr) ? WB_MEM : r_ainc ? INC : FETCH;
      WB_MEM:  w_next = !mem_rdy ? WB_MEM : r_ainc ? INC : FETCH;
      INC:     w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end
  always_comb begin
    w_mab = 3'd0;
    w_req = 1'b0;
    w_mw  = 1'b0;
    w_rw  = 1'b0;
    w_mpc = 2'd0;
    w_md  = 2'd0;
    w_ir  = 1'b0;
    w_xs  = 1'b0;
    w_xd  = 1'b0;
    w_src = 1'b0;
    w_dst = 1'b0;
    w_ex  = 1'b0;
    case (r_state)
      FETCH: begin
        w_req = 1'b1;
        w_ir  = mem_rdy;
        w_mpc = {1'b0, mem_rdy};
      end
      EXT_SRC: begin
        w_req = 1'b1;
        w_xs  = mem_rdy;
        w_mpc = {1'b0, mem_rdy};
      end
      SRC_RD: begin
        w_req = 1'b1;
        w_mab = (as == 2'b01) ? 3'd2 : 3'd1;
        w_src = mem_rdy;
      end
      EXT_DST: begin
        w_req = 1'b1;
        w_xd  = mem_rdy;
        w_mpc = {1'b0, mem_rdy};
      end
      DST_RD: begin
        w_req = 1'b1;
        w_mab = 3'd2;
        w_dst = mem_rdy;
      end
      EXEC: begin
        w_ex = 1'b1;
        w_rw = wr && !ad && !fmt_j;
      end
      WB_MEM: begin
        w_req = 1'b1;
        w_mab = 3'd2;
        w_mw  = 1'b1;
      end
      INC: begin
        w_rw = 1'b1;
        w_md = 2'd2;
      end
      default: ;
    endcase
  end
  // ainc remembers an @Rn+ source until the register update in INC
  always_ff @(posedge clk or posedge rst)
    if (rst)                                                     r_ainc <= 1'b0;
    else if (r_state == FETCH)                                   r_ainc <= 1'b0;
    else if (r_state == SRC_RD && mem_rdy && as == 2'b11 && !imm) r_ainc <= 1'b1;
  assign w_retire = (w_next == FETCH) &&
                    (r_state == EXEC || r_state == WB_MEM || r_state == INC);
  always_ff @(posedge clk or posedge rst)
    if (rst)           r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + 1'b1;
  // strobes and writes are masked combinationally so reset kills them at once
  assign MAB_sel   = w_mab;
  assign mem_req   = w_req;
  assign MW        = w_mw  && !rst;
  assign RW        = w_rw  && !rst;
  assign MPC       = rst ? 2'd0 : w_mpc;
  assign MD        = rst ? 2'd0 : w_md;
  assign ir_ld     = w_ir  && !rst;
  assign xs_ld     = w_xs  && !rst;
  assign xd_ld     = w_xd  && !rst;
  assign src_ld    = w_src && !rst;
  assign dst_ld    = w_dst && !rst;
  assign exec      = w_ex  && !rst;
  assign instr_cnt = r_cnt;
  assign state     = r_state;
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: randomized instruction stream checked against a phase-list model of mem_seq.
module tb_mem_seq;
  localparam int CW = 4;
  logic          clk, rst, mem_rdy, fmt_j, ad, cg, imm, wr;
  logic [1:0]    as;
  logic [2:0]    MAB_sel;
  logic          mem_req, MW, RW, ir_ld, xs_ld, xd_ld, src_ld, dst_ld, exec;
  logic [1:0]    MPC, MD;
  logic [CW-1:0] instr_cnt;
  logic [3:0]    state;
  logic [15:0]   obs;
  int            n_cmp, n_bad;
  int            m_cnt;
  mem_seq #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem_rdy(mem_rdy), .fmt_j(fmt_j), .as(as), .ad(ad),
    .cg(cg), .imm(imm), .wr(wr), .MAB_sel(MAB_sel), .mem_req(mem_req), .MW(MW),
    .RW(RW), .MPC(MPC), .MD(MD), .ir_ld(ir_ld), .xs_ld(xs_ld), .xd_ld(xd_ld),
    .src_ld(src_ld), .dst_ld(dst_ld), .exec(exec), .instr_cnt(instr_cnt), .state(state)
  );
  assign obs = {MAB_sel, mem_req, MW, RW, MPC, MD, ir_ld, xs_ld, xd_ld, src_ld, dst_ld, exec};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // expected output vector for a phase, packed like obs
  function automatic logic [15:0] exp_out(input int p, input bit r);
    logic [2:0] mab = 3'd0;
    logic       req = 1'b0, mw = 1'b0, rw = 1'b0;
    logic [1:0] mpc = 2'd0, md = 2'd0;
    logic [5:0] st  = 6'd0;
    case (p)
      0: begin req = 1; mpc = {1'b0, r}; st[5] = r; end
      2: begin req = 1; mpc = {1'b0, r}; st[4] = r; end
      3: begin req = 1; mab = (as == 2'b01) ? 3'd2 : 3'd1; st[2] = r; end
      4: begin req = 1; mpc = {1'b0, r}; st[3] = r; end
      5: begin req = 1; mab = 3'd2; st[1] = r; end
      6: begin st[0] = 1; rw = wr && !ad && !fmt_j; end
      7: begin req = 1; mab = 3'd2; mw = 1; end
      8: begin rw = 1; md = 2'd2; end
      default: ;
    endcase
    return {mab, req, mw, rw, mpc, md, st};
  endfunction
  // one clock in phase p with the given mem_rdy; entered and left at posedge+1
  task automatic step(input int p, input bit r);
    mem_rdy = r;
    #2;
    chk("state", 32'(state), 32'(p));
    chk("outs", 32'(obs), 32'(exp_out(p, r)));
    chk("cnt", 32'(instr_cnt), 32'(m_cnt));
    @(posedge clk);
    #1;
  endtask
  task automatic bus(input int p, input int nw);
    int w;
    w = (nw >= 0) ? nw : int'($urandom_range(0, 2));
    repeat (w) step(p, 1'b0);
    step(p, 1'b1);
  endtask
  // phase list follows from the instruction's addressing needs
  task automatic run_instr(input bit fj, input bit [1:0] a, input bit d, input bit c,
                           input bit i, input bit w, input int src_wait);
    bit xs, sr, ai;
    fmt_j = fj; as = a; ad = d; cg = c; imm = i; wr = w;
    xs = !fj && ((a == 2'b01 && !c) || i);
    sr = !fj && (xs ? (a == 2'b01) : (a[1] && !c));
    ai = sr && a == 2'b11 && !i;
    bus(0, -1);
    step(1, 1'($urandom));
    if (xs) bus(2, -1);
    if (sr) bus(3, src_wait);
    if (!fj && d) begin
      bus(4, -1);
      bus(5, -1);
    end
    step(6, 1'($urandom));
    if (d && w) bus(7, -1);
    if (ai) step(8, 1'($urandom));
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask
  initial begin
    bit fj, d, c, i, w;
    bit [1:0] a;
    n_cmp = 0; n_bad = 0; m_cnt = 0;
    rst = 1'b1; mem_rdy = 1'b1;
    fmt_j = 0; as = 0; ad = 0; cg = 0; imm = 0; wr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    chk("rst_outs", 32'(obs), 32'h1000);
    rst = 1'b0;
    run_instr(0, 2'b00, 0, 0, 0, 1, -1);
    run_instr(0, 2'b11, 1, 0, 1, 1, -1);
    run_instr(0, 2'b11, 0, 0, 0, 1, -1);
    run_instr(0, 2'b01, 0, 0, 0, 0, 3);
    repeat (300) begin
      fj = ($urandom % 4) == 0;
      a  = 2'($urandom);
      if (fj) begin
        d = 0; w = 0; c = 0; i = 0;
      end else begin
        i = (a == 2'b11) && ($urandom % 2 == 1);
        c = !i && a != 2'b00 && ($urandom % 3 == 0);
        d = 1'($urandom);
        w = 1'($urandom);
      end
      run_instr(fj, a, d, c, i, w, -1);
    end
    while (m_cnt != (1 << CW) - 1) run_instr(1, 2'b00, 0, 0, 0, 0, -1);
    chk("pre_wrap", 32'(instr_cnt), 32'((1 << CW) - 1));
    run_instr(1, 2'b00, 0, 0, 0, 0, -1);
    chk("wrap", 32'(instr_cnt), 0);
    fmt_j = 0; as = 2'b00; ad = 1; cg = 0; imm = 0; wr = 1;
    bus(0, 0);
    step(1, 1'b1);
    bus(4, 0);
    bus(5, 0);
    step(6, 1'b1);
    mem_rdy = 1'b0;
    #2;
    chk("wb_mw", 32'(MW), 1);
    chk("wb_state", 32'(state), 7);
    rst = 1'b1;
    #1;
    chk("abort_mw", 32'(MW), 0);
    chk("abort_state", 32'(state), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0;
    chk("post_state", 32'(state), 0);
    chk("post_cnt", 32'(instr_cnt), 0);
    run_instr(0, 2'b10, 1, 0, 0, 1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on posedge clk.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port mem_rdy, input, 1 bit: memory completes the current bus cycle this clock.
REQ-005 The block SHALL have port fmt_j, input, 1 bit: IR holds a jump instruction.
REQ-006 The block SHALL have port as, input, 2 bits: source addressing mode from IR.
REQ-007 The block SHALL have port ad, input, 1 bit: destination is indexed memory (0 for format II/J).
REQ-008 The block SHALL have port cg, input, 1 bit: constant generator source (SA = R2/R3 with As != 0).
REQ-009 The block SHALL have port imm, input, 1 bit: immediate source (SA = PC, As = 11).
REQ-010 The block SHALL have port wr, input, 1 bit: instruction writes its result (0 for CMP, BIT, jumps).
REQ-011 The block SHALL have port MAB_sel, output, 3 bits: MAB source (0 = PC, 1 = Sout, 2 = CALC).
REQ-012 The block SHALL have port mem_req, output, 1 bit: bus cycle active.
REQ-013 The block SHALL have ports MW and RW, outputs, 1 bit each: memory write and register-file write.
REQ-014 The block SHALL have port MPC, output, 2 bits: PC mux select (0 = hold, 1 = PC + 2).
REQ-015 The block SHALL have port MD, output, 2 bits: Din mux select (0 = FU result, 2 = autoincrement).
REQ-016 The block SHALL have ports ir_ld, xs_ld, xd_ld, src_ld, dst_ld, exec, outputs, 1 bit each: load strobes for IR, source extension word, destination extension word, source operand and destination operand; exec is the FU execute strobe.
REQ-017 The block SHALL have port instr_cnt, output, CNT_W bits: retired-instruction count.
REQ-018 The block SHALL have port state, output, 4 bits: current FSM state, for debug.

Function
REQ-019 The FSM SHALL have the states FETCH=0, DECODE=1, EXT_SRC=2, SRC_RD=3, EXT_DST=4, DST_RD=5, EXEC=6, WB_MEM=7 and INC=8; encodings 9 to 15 SHALL go to FETCH on the next clock.
REQ-020 In the bus states (FETCH, EXT_SRC, SRC_RD, EXT_DST, DST_RD, WB_MEM), mem_req SHALL be 1, and the state SHALL be held with outputs stable while mem_rdy = 0; the load strobes and MPC = 1 SHALL assert only in the cycle where mem_rdy = 1.
REQ-021 FETCH SHALL drive MAB_sel = 0; on mem_rdy it SHALL assert ir_ld = 1 and MPC = 1, then go to DECODE.
REQ-022 DECODE SHALL be a single cycle with no bus cycle, and the next state SHALL be chosen in this priority order:
- fmt_j -> EXEC;
- (as = 01 and !cg) or imm -> EXT_SRC;
- as[1] and !cg -> SRC_RD;
- ad -> EXT_DST;
- otherwise -> EXEC.
REQ-023 EXT_SRC SHALL drive MAB_sel = 0 and, on mem_rdy, assert xs_ld = 1 and MPC = 1; the next state SHALL be SRC_RD if as = 01, else EXT_DST if ad, else EXEC.
REQ-024 SRC_RD SHALL drive MAB_sel = 2 if as = 01, else 1; on mem_rdy it SHALL assert src_ld = 1, and the next state SHALL be EXT_DST if ad, else EXEC.
REQ-025 The internal flag ainc SHALL be set when leaving SRC_RD with as = 11 and !imm, and cleared in FETCH.
REQ-026 EXT_DST SHALL drive MAB_sel = 0 and, on mem_rdy, assert xd_ld = 1 and MPC = 1, then go to DST_RD.
REQ-027 DST_RD SHALL drive MAB_sel = 2 and, on mem_rdy, assert dst_ld = 1, then go to EXEC.
REQ-028 EXEC SHALL be one cycle with exec = 1 and RW = wr & !ad & !fmt_j; the next state SHALL be WB_MEM if ad & wr, else INC if ainc, else FETCH.
REQ-029 WB_MEM SHALL drive MAB_sel = 2 and MW = 1; on mem_rdy it SHALL go to INC if ainc, else FETCH.
REQ-030 INC SHALL be one cycle with RW = 1 and MD = 2, then go to FETCH.
REQ-031 In every state, outputs not named for that state SHALL be 0.
REQ-032 instr_cnt SHALL increment by 1 on each transition into FETCH from EXEC, WB_MEM or INC, and SHALL wrap from all-ones to 0.
REQ-033 Inputs fmt_j, as, ad, cg, imm and wr SHALL be sampled only in DECODE through FETCH and SHALL be held stable by the decoder while the IR is unchanged.

Reset
REQ-034 While rst = 1, the FSM SHALL be forced to FETCH, ainc and instr_cnt SHALL be forced to 0, and all strobes, MW, RW, MPC and MD SHALL be forced to 0.
REQ-035 After rst is released, mem_req = 1 and MAB_sel = 0 SHALL appear in the first cycle.
REQ-036 rst asserted mid-operation (for example in WB_MEM with mem_rdy = 0) SHALL abort the cycle immediately, with MW = 0 in the same cycle.

Verification
REQ-037 Register-mode ADD (as = 00, ad = 0, wr = 1) with mem_rdy tied to 1 -> the state sequence SHALL be 0, 1, 6, 0, with RW = 1 in EXEC and instr_cnt 0 -> 1.
REQ-038 Immediate MOV #0x1234 (imm = 1, ad = 1) -> the state sequence SHALL be 0, 1, 2, 4, 5, 6, 7, 0; MPC = 1 in exactly three cycles; MW = 1 once; RW = 0.
REQ-039 Autoincrement (as = 11, imm = 0, ad = 0, wr = 1) -> the state sequence SHALL be 0, 1, 3, 6, 8, 0, with MAB_sel = 1 in SRC_RD, MD = 2 and RW = 1 in INC.
REQ-040 CMP with indexed source, mem_rdy held low for 3 cycles in SRC_RD -> SRC_RD SHALL last 4 cycles, src_ld SHALL pulse once, and RW SHALL stay 0 throughout.
REQ-041 Preload instr_cnt to all-ones via 2^CNT_W - 1 jumps, then run one more jump -> instr_cnt SHALL read 0.
REQ-042 rst pulsed in WB_MEM -> MW SHALL fall asynchronously, and after release state = 0 and instr_cnt = 0.
